// File: rtl/fifo_pkg.sv
// Helpers shared by the read- and write-side controllers of the async FIFO.
// Conversions work on a wide container; callers zero-extend and slice to their pointer width.
package fifo_pkg;

  localparam int GW = 32;

  function automatic int fifo_depth(input int p_width);
    return 2 ** (p_width - 1);
  endfunction

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB; zero-extended upper bits leave the low bits unaffected.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the dual-clock FIFO, entirely in the w_clk domain.
// Handshake: w_inc is a request; it is accepted (w_en=1) in any cycle where w_full=0, else dropped.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int P_WIDTH   = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic               w_clk,
  input  logic               wrst,
  input  logic               w_inc,
  input  logic [P_WIDTH-1:0] sync_rptr,
  input  logic               w_clr_ovf,
  output logic               w_en,
  output logic [P_WIDTH-2:0] w_addr,
  output logic [P_WIDTH-1:0] w_ptr_gray,
  output logic               w_full,
  output logic               w_afull,
  output logic [P_WIDTH-1:0] w_count,
  output logic               w_overflow
);

  localparam int DEPTH = fifo_depth(P_WIDTH);
  localparam logic [P_WIDTH-1:0] AF_LEVEL = P_WIDTH'(DEPTH - AF_MARGIN);

  logic [P_WIDTH-1:0] wr_pointer;
  logic [P_WIDTH-1:0] wr_pointer_next;
  logic [P_WIDTH-1:0] rbin;
  logic [GW-1:0]      gray_next_ext;
  logic [GW-1:0]      rbin_ext;
  logic               unused_hi;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  always_comb begin
    w_full          = (w_ptr_gray == {~sync_rptr[P_WIDTH-1:P_WIDTH-2], sync_rptr[P_WIDTH-3:0]});
    w_en            = w_inc & ~w_full;
    wr_pointer_next = wr_pointer + {{(P_WIDTH-1){1'b0}}, w_en};
    gray_next_ext   = bin2gray(GW'(wr_pointer_next));
    rbin_ext        = gray2bin(GW'(sync_rptr));
    rbin            = rbin_ext[P_WIDTH-1:0];
    w_count         = wr_pointer - rbin;
    w_afull         = (w_count >= AF_LEVEL);
    w_addr          = wr_pointer[P_WIDTH-2:0];
  end

  assign unused_hi = ^{gray_next_ext[GW-1:P_WIDTH], rbin_ext[GW-1:P_WIDTH]};

  // Gray is registered from the next binary value so it tracks wr_pointer with no lag.
  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      wr_pointer <= '0;
      w_ptr_gray <= '0;
      w_overflow <= 1'b0;
    end else begin
      wr_pointer <= wr_pointer_next;
      w_ptr_gray <= gray_next_ext[P_WIDTH-1:0];
      if (w_inc & w_full) begin
        w_overflow <= 1'b1;
      end else if (w_clr_ovf) begin
        w_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboarded bench for fifo_wr_ctrl: directed fill/overflow/wrap/reset plus a random run
// against a free-running reader with a two-stage synchronizer model.
module tb_fifo_wr_ctrl;

  localparam int PW    = 4;
  localparam int DEPTH = 8;
  localparam int W     = 20;

  // clock / reset
  logic w_clk = 1'b0;
  logic wrst  = 1'b1;
  always #5 w_clk = ~w_clk;

  logic          w_inc     = 1'b0;
  logic          w_clr_ovf = 1'b0;
  logic [PW-1:0] sync_rptr = '0;

  logic          w_en, w_full, w_afull, w_overflow;
  logic [PW-2:0] w_addr;
  logic [PW-1:0] w_ptr_gray, w_count;

  logic          w_en1, w_full1, w_afull1, w_overflow1;
  logic [PW-2:0] w_addr1;
  logic [PW-1:0] w_ptr_gray1, w_count1;

  fifo_wr_ctrl #(.P_WIDTH(PW), .AF_MARGIN(2)) dut (
    .w_clk(w_clk), .wrst(wrst), .w_inc(w_inc), .sync_rptr(sync_rptr), .w_clr_ovf(w_clr_ovf),
    .w_en(w_en), .w_addr(w_addr), .w_ptr_gray(w_ptr_gray), .w_full(w_full),
    .w_afull(w_afull), .w_count(w_count), .w_overflow(w_overflow)
  );

  fifo_wr_ctrl #(.P_WIDTH(PW), .AF_MARGIN(1)) dut_m1 (
    .w_clk(w_clk), .wrst(wrst), .w_inc(w_inc), .sync_rptr(sync_rptr), .w_clr_ovf(w_clr_ovf),
    .w_en(w_en1), .w_addr(w_addr1), .w_ptr_gray(w_ptr_gray1), .w_full(w_full1),
    .w_afull(w_afull1), .w_count(w_count1), .w_overflow(w_overflow1)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit skip_gray = 1'b1;

  // reference model state
  int m_total = 0;
  int rd_true = 0;
  int s1 = 0;
  int s2 = 0;
  int rd_seen = 0;
  bit m_ovf = 1'b0;
  bit p_inc = 1'b0;
  bit p_clr = 1'b0;
  bit p_full = 1'b0;
  bit random_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [31:0] v;
    v = b;
    return v[3:0] ^ (v[3:0] >> 1);
  endfunction

  task automatic model_edge();
    if (p_inc && !p_full) m_total++;
    if (p_inc && p_full) m_ovf = 1'b1;
    else if (p_clr) m_ovf = 1'b0;
  endtask

  // driver: one w_clk cycle; inputs change 1ns after the edge, expectation pushed for this cycle
  task automatic drive_cycle(input bit inc, input int rbin, input bit clr);
    int ptr, cnt, occ;
    bit full;
    logic [31:0] occ_v, cnt_v, ptr_v;
    @(posedge w_clk);
    model_edge();
    if (random_mode) begin
      if ($urandom_range(0, 2) == 0 && rd_true < m_total) rd_true++;
      s2 = s1;
      s1 = rd_true % 16;
      rd_seen = s2;
    end else begin
      rd_seen = rbin;
    end
    #1;
    w_inc     = inc;
    w_clr_ovf = clr;
    sync_rptr = to_gray(rd_seen);
    ptr  = m_total % 16;
    cnt  = (ptr - rd_seen + 16) % 16;
    full = (cnt == DEPTH);
    occ  = random_mode ? (m_total - rd_true) : cnt;
    occ_v = occ;
    cnt_v = cnt;
    ptr_v = ptr;
    exp_q.push_back({occ_v[3:0], (cnt >= DEPTH - 1), m_ovf, cnt_v[3:0], (cnt >= DEPTH - 2),
                     full, to_gray(ptr), ptr_v[2:0], (inc && !full)});
    p_inc  = inc;
    p_clr  = clr;
    p_full = full;
  endtask

  // monitor: pops one expectation per cycle and compares on the falling edge
  initial begin
    logic [W-1:0] e;
    logic [PW-1:0] prev_g;
    bit prev_en;
    prev_g  = '0;
    prev_en = 1'b0;
    forever begin
      @(negedge w_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("w_en",       w_en,       e[0]);
        check("w_addr",     w_addr,     e[3:1]);
        check("w_ptr_gray", w_ptr_gray, e[7:4]);
        check("w_full",     w_full,     e[8]);
        check("w_afull",    w_afull,    e[9]);
        check("w_count",    w_count,    e[13:10]);
        check("w_overflow", w_overflow, e[14]);
        check("w_afull_m1", w_afull1,   e[15]);
        check("count_ge_true_occ", (w_count >= e[19:16]), 1);
        if (w_en) check("accept_while_truly_full", (e[19:16] < DEPTH), 1);
        if (!skip_gray) check("gray_step", $countones(w_ptr_gray ^ prev_g), prev_en ? 1 : 0);
        skip_gray = 1'b0;
        prev_g  = w_ptr_gray;
        prev_en = e[0];
      end
    end
  end

  initial begin
    // reset state
    #3;
    check("rst_gray",  w_ptr_gray, 0);
    check("rst_addr",  w_addr,     0);
    check("rst_count", w_count,    0);
    check("rst_full",  w_full,     0);
    check("rst_afull", w_afull,    0);
    check("rst_ovf",   w_overflow, 0);
    check("rst_en",    w_en,       0);
    #9 wrst = 1'b0;

    // bring pointer to 5, then reset mid-cycle
    repeat (5) drive_cycle(1, 0, 0);
    drive_cycle(0, 0, 0);
    @(negedge w_clk);
    check("pre_rst_addr", w_addr, 5);
    #2 wrst = 1'b1;
    #1;
    check("mid_rst_gray",  w_ptr_gray, 0);
    check("mid_rst_addr",  w_addr,     0);
    check("mid_rst_count", w_count,    0);
    check("mid_rst_full",  w_full,     0);
    check("mid_rst_ovf",   w_overflow, 0);
    m_total = 0; m_ovf = 0; p_inc = 0; p_clr = 0; p_full = 0; rd_seen = 0;
    skip_gray = 1'b1;
    @(posedge w_clk);
    @(negedge w_clk);
    wrst = 1'b0;

    // fill with reader parked at 0
    repeat (8) drive_cycle(1, 0, 0);
    drive_cycle(1, 0, 0);
    @(negedge w_clk);
    check("fill_gray",  w_ptr_gray, 4'b1100);
    check("fill_count", w_count,    8);
    check("fill_full",  w_full,     1);
    check("fill_en",    w_en,       0);

    // overflow set, hold, clear, set-wins
    drive_cycle(1, 0, 0);
    drive_cycle(0, 0, 1);
    drive_cycle(1, 0, 1);
    drive_cycle(0, 1, 0);
    @(negedge w_clk);
    check("ovf_set_wins", w_overflow, 1);
    check("ovf_ptr_held", w_ptr_gray, 4'b1100);

    // drain two slots then wrap
    drive_cycle(0, 2, 0);
    @(negedge w_clk);
    check("drain_count",    w_count,  6);
    check("drain_full",     w_full,   0);
    check("drain_afull",    w_afull,  1);
    check("drain_afull_m1", w_afull1, 0);
    drive_cycle(1, 2, 0);
    drive_cycle(1, 2, 0);
    drive_cycle(0, 2, 0);
    @(negedge w_clk);
    check("wrap_gray", w_ptr_gray, 4'b1111);
    check("wrap_addr", w_addr,     2);
    check("wrap_full", w_full,     1);

    // random run with free-running reader behind a 2-flop sync
    rd_true = rd_seen;
    s1 = rd_seen;
    s2 = rd_seen;
    random_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 0, $urandom_range(0, 31) == 0);
    end
    drive_cycle(0, 0, 0);
    repeat (3) @(negedge w_clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
